// File: rtl/t05_find_least.sv
// Scans the histogram table through the shared SRAM read port and reports the two
// characters with the smallest non-zero counts, their counts and the summed count.
module t05_find_least #(
   parameter int unsigned NUM_ENTRIES = 256,
   parameter int unsigned BASE_ADDR   = 0,
   parameter int unsigned EN_CODE     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  en_state,
   input  logic [31:0] sram_in,
   input  logic        busy_i,
   input  logic        restart,
   output logic [1:0]  wr_r_en,
   output logic [8:0]  addr,
   output logic [8:0]  least1,
   output logic [8:0]  least2,
   output logic [31:0] cnt1,
   output logic [31:0] cnt2,
   output logic [31:0] sum,
   output logic        done
);

   localparam logic [8:0]  IdxNone  = 9'h1FF;
   localparam logic [31:0] CntNone  = 32'hFFFF_FFFF;
   localparam logic [1:0]  CmdRead  = 2'd0;
   localparam logic [1:0]  CmdIdle  = 2'd3;

   typedef enum logic [2:0] {StIdle, StReq, StWait, StCmp, StDone} state_t;

   state_t      state;
   logic [8:0]  idx;
   logic [31:0] data;

   logic        en;
   logic        last;
   logic [8:0]  c_least1;
   logic [8:0]  c_least2;
   logic [31:0] c_cnt1;
   logic [31:0] c_cnt2;
   logic [31:0] c_sum;

   assign en   = (en_state == 4'(EN_CODE));
   assign last = (idx == 9'(NUM_ENTRIES - 1));

   // Insertion of the latched word into the two-entry sorted list; strict compares keep
   // the lower index on ties and never admit an all-ones count.
   always_comb begin
      c_least1 = least1;
      c_least2 = least2;
      c_cnt1   = cnt1;
      c_cnt2   = cnt2;
      if (data != '0) begin
         if (data < cnt1) begin
            c_least2 = least1;
            c_cnt2   = cnt1;
            c_least1 = idx;
            c_cnt1   = data;
         end else if (data < cnt2) begin
            c_least2 = idx;
            c_cnt2   = data;
         end
      end
      if (c_least1 == IdxNone) begin
         c_sum = '0;
      end else if (c_least2 == IdxNone) begin
         c_sum = c_cnt1;
      end else begin
         c_sum = c_cnt1 + c_cnt2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= StIdle;
         idx     <= '0;
         data    <= '0;
         wr_r_en <= CmdIdle;
         addr    <= '0;
         least1  <= IdxNone;
         least2  <= IdxNone;
         cnt1    <= CntNone;
         cnt2    <= CntNone;
         sum     <= '0;
         done    <= 1'b0;
      end else if (en) begin
         unique case (state)
            StIdle: begin
               idx     <= '0;
               least1  <= IdxNone;
               least2  <= IdxNone;
               cnt1    <= CntNone;
               cnt2    <= CntNone;
               done    <= 1'b0;
               wr_r_en <= CmdRead;
               addr    <= 9'(BASE_ADDR);
               state   <= StReq;
            end
            StReq: begin
               wr_r_en <= CmdIdle;
               state   <= StWait;
            end
            StWait: begin
               if (!busy_i) begin
                  data  <= sram_in;
                  state <= StCmp;
               end
            end
            StCmp: begin
               least1 <= c_least1;
               least2 <= c_least2;
               cnt1   <= c_cnt1;
               cnt2   <= c_cnt2;
               if (last) begin
                  sum   <= c_sum;
                  done  <= 1'b1;
                  state <= StDone;
               end else begin
                  idx     <= idx + 9'd1;
                  addr    <= 9'(BASE_ADDR) + idx + 9'd1;
                  wr_r_en <= CmdRead;
                  state   <= StReq;
               end
            end
            StDone: begin
               wr_r_en <= CmdIdle;
               if (restart) begin
                  done  <= 1'b0;
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_t05_find_least.sv
// Randomized bench for t05_find_least: SRAM model, two-pass selection reference model and
// a per-cycle compare step, plus directed scans pinned to hand-computed results.
module tb_t05_find_least;

   localparam int unsigned N    = 256;
   localparam int unsigned BASE = 0;
   localparam int unsigned EN   = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  en_state;
   logic [31:0] sram_in;
   logic        busy_i;
   logic        restart;
   logic [1:0]  wr_r_en;
   logic [8:0]  addr;
   logic [8:0]  least1;
   logic [8:0]  least2;
   logic [31:0] cnt1;
   logic [31:0] cnt2;
   logic [31:0] sum;
   logic        done;

   t05_find_least #(
      .NUM_ENTRIES (N),
      .BASE_ADDR   (BASE),
      .EN_CODE     (EN)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en_state (en_state),
      .sram_in  (sram_in),
      .busy_i   (busy_i),
      .restart  (restart),
      .wr_r_en  (wr_r_en),
      .addr     (addr),
      .least1   (least1),
      .least2   (least2),
      .cnt1     (cnt1),
      .cnt2     (cnt2),
      .sum      (sum),
      .done     (done)
   );

   always #5 clk = ~clk;

   // SRAM: a read command captures the address; data shows up once busy is low.
   logic [31:0] mem [0:511];
   logic [8:0]  rd_addr = '0;
   always @(posedge clk) if (wr_r_en == 2'd0) rd_addr <= addr;
   assign sram_in = busy_i ? 32'hDEAD_BEEF : mem[rd_addr];

   int   total = 0;
   int   bad = 0;
   int   exp_idx = 0;
   logic done_prev = 1'b0;
   bit   rand_mode = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: smallest (count, index) pair, then smallest among the remaining entries.
   task automatic model(output logic [8:0] l1, output logic [8:0] l2,
                        output logic [31:0] c1, output logic [31:0] c2, output logic [31:0] s);
      l1 = 9'h1FF; c1 = 32'hFFFF_FFFF;
      l2 = 9'h1FF; c2 = 32'hFFFF_FFFF;
      for (int i = 0; i < int'(N); i++) begin
         if (mem[BASE + i] != 0 && mem[BASE + i] < c1) begin
            l1 = 9'(i); c1 = mem[BASE + i];
         end
      end
      for (int i = 0; i < int'(N); i++) begin
         if (9'(i) != l1 && mem[BASE + i] != 0 && mem[BASE + i] < c2) begin
            l2 = 9'(i); c2 = mem[BASE + i];
         end
      end
      if (l1 == 9'h1FF) s = 0;
      else if (l2 == 9'h1FF) s = c1;
      else s = c1 + c2;
   endtask

   task automatic cycle_check();
      logic [8:0]  l1, l2;
      logic [31:0] c1, c2, s;
      @(negedge clk);
      if (!rst) begin
         total++;
         if (wr_r_en != 2'd0 && wr_r_en != 2'd3) begin
            bad++;
            $display("FAIL cmd_legal: got %0d expected 0 or 3", wr_r_en);
         end
         if (wr_r_en == 2'd0 && en_state == 4'(EN)) begin
            check("req_addr", 32'(addr), 32'(BASE + exp_idx));
            exp_idx++;
         end
         if (done && !done_prev) begin
            model(l1, l2, c1, c2, s);
            check("m_least1", 32'(least1), 32'(l1));
            check("m_least2", 32'(least2), 32'(l2));
            check("m_cnt1", cnt1, c1);
            check("m_cnt2", cnt2, c2);
            check("m_sum", sum, s);
            check("m_req_count", 32'(exp_idx), 32'(N));
         end
      end
      done_prev = done;
   endtask

   task automatic tick();
      cycle_check();
      @(posedge clk);
      #1;
      if (rand_mode) begin
         busy_i   = ($urandom_range(0, 3) == 0);
         en_state = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'(EN);
      end
   endtask

   task automatic wait_done(input int limit, output int n);
      n = 0;
      while (!done && n < limit) begin
         tick();
         n++;
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL done_timeout: got done=0 after %0d cycles expected done=1", n);
      end
      rand_mode = 1'b0;
      busy_i    = 1'b0;
      en_state  = 4'(EN);
      tick();
   endtask

   task automatic restart_scan();
      rand_mode = 1'b0;
      en_state  = 4'(EN);
      busy_i    = 1'b0;
      restart   = 1'b1;
      exp_idx   = 0;
      tick();
      restart   = 1'b0;
   endtask

   task automatic expect_result(input string tag, input logic [8:0] l1, input logic [8:0] l2,
                                input logic [31:0] c1, input logic [31:0] c2,
                                input logic [31:0] s);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_least1"}, 32'(least1), 32'(l1));
      check({tag, "_least2"}, 32'(least2), 32'(l2));
      check({tag, "_cnt1"}, cnt1, c1);
      check({tag, "_cnt2"}, cnt2, c2);
      check({tag, "_sum"}, sum, s);
   endtask

   task automatic expect_reset(input string tag);
      check({tag, "_wr_r_en"}, 32'(wr_r_en), 32'd3);
      check({tag, "_addr"}, 32'(addr), 32'd0);
      check({tag, "_least1"}, 32'(least1), 32'h1FF);
      check({tag, "_least2"}, 32'(least2), 32'h1FF);
      check({tag, "_cnt1"}, cnt1, 32'hFFFF_FFFF);
      check({tag, "_cnt2"}, cnt2, 32'hFFFF_FFFF);
      check({tag, "_sum"}, sum, 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 512; i++) mem[i] = '0;
   endtask

   task automatic random_mem(input bit sparse);
      int unsigned r;
      clear_mem();
      for (int i = 0; i < int'(N); i++) begin
         r = $urandom_range(0, 9);
         if (sparse) mem[BASE + i] = ($urandom_range(0, 63) == 0) ? $urandom_range(1, 9) : 0;
         else if (r < 4) mem[BASE + i] = 0;
         else if (r < 8) mem[BASE + i] = $urandom_range(1, 20);
         else if (r == 8) mem[BASE + i] = $urandom;
         else mem[BASE + i] = 32'hFFFF_FFFF;
      end
   endtask

   task automatic load_abc();
      clear_mem();
      mem[BASE + 9'h61] = 5;
      mem[BASE + 9'h62] = 2;
      mem[BASE + 9'h63] = 9;
   endtask

   int  n;
   int  k;
   logic [8:0] a0;
   logic [1:0] w0;

   initial begin
      rst = 1'b1; en_state = 4'(EN); busy_i = 1'b0; restart = 1'b0;
      load_abc();
      tick();
      tick();
      expect_reset("reset");

      // Basic scan; done is visible in the (3N+2)-th cycle counting the IDLE cycle.
      rst = 1'b0;
      exp_idx = 0;
      wait_done(5000, n);
      check("scan_cycles", 32'(n), 32'(3 * N + 1));
      expect_result("abc", 9'h62, 9'h61, 32'd2, 32'd5, 32'd7);

      // restart in DONE drops done on the next cycle.
      restart_scan();
      check("restart_done_low", 32'(done), 32'd0);
      clear_mem();
      mem[BASE + 9'h10] = 3; mem[BASE + 9'h05] = 3; mem[BASE + 9'h20] = 3;
      wait_done(5000, n);
      expect_result("tie", 9'h05, 9'h10, 32'd3, 32'd3, 32'd6);

      restart_scan();
      clear_mem();
      mem[BASE + 9'h1A] = 4;
      wait_done(5000, n);
      expect_result("single", 9'h1A, 9'h1FF, 32'd4, 32'hFFFF_FFFF, 32'd4);

      restart_scan();
      clear_mem();
      wait_done(5000, n);
      expect_result("zero", 9'h1FF, 9'h1FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);

      // busy stall while reading index 7.
      restart_scan();
      load_abc();
      k = 0;
      while (!(wr_r_en == 2'd0 && addr == 9'(BASE + 7)) && k < 100) begin
         tick();
         k++;
      end
      check("stall_found_req7", 32'(k < 100), 32'd1);
      busy_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("stall_wr_r_en", 32'(wr_r_en), 32'd3);
         check("stall_addr", 32'(addr), 32'(BASE + 7));
      end
      busy_i = 1'b0;
      wait_done(5000, n);
      expect_result("stall", 9'h62, 9'h61, 32'd2, 32'd5, 32'd7);

      // en_state dip mid-scan freezes everything.
      restart_scan();
      random_mem(1'b0);
      for (int i = 0; i < 150; i++) tick();
      en_state = 4'd1;
      a0 = addr;
      w0 = wr_r_en;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("freeze_addr", 32'(addr), 32'(a0));
         check("freeze_wr_r_en", 32'(wr_r_en), 32'(w0));
      end
      en_state = 4'(EN);
      wait_done(5000, n);

      // restart outside DONE is ignored; the request sequence must continue unbroken.
      restart_scan();
      random_mem(1'b0);
      for (int i = 0; i < 50; i++) tick();
      restart = 1'b1;
      tick();
      restart = 1'b0;
      wait_done(5000, n);

      // Asynchronous reset mid-scan, then a full scan from scratch.
      restart_scan();
      random_mem(1'b0);
      for (int i = 0; i < 100; i++) tick();
      rst = 1'b1;
      #1;
      expect_reset("midrst");
      tick();
      rst = 1'b0;
      exp_idx = 0;
      load_abc();
      wait_done(5000, n);
      expect_result("post_rst", 9'h62, 9'h61, 32'd2, 32'd5, 32'd7);

      // Random tables with random busy stalls and enable dips.
      for (int s = 0; s < 8; s++) begin
         restart_scan();
         random_mem(s % 3 == 2);
         rand_mode = 1'b1;
         wait_done(8000, n);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/t05_find_least.md
Name: t05_find_least

Overview:
- Stage directly downstream of the histogram stage in the team 05 Huffman compressor.
- Once the histogram table in SRAM is complete, it scans every histogram entry through the shared SRAM read port.
- It finds the two characters with the smallest non-zero counts and publishes their indices, counts and summed count.
- The tree-building stage consumes these results and can request a rescan through restart.

Parameters:
- NUM_ENTRIES, 256: number of histogram words scanned, at addresses BASE_ADDR to BASE_ADDR+NUM_ENTRIES-1.
- BASE_ADDR, 0: SRAM word address of histogram entry 0.
- EN_CODE, 2: value of en_state that enables this block.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- en_state  input  4  top-level phase; registers update only when en_state == EN_CODE, otherwise all registers hold
- sram_in  input  32  SRAM read data; valid in the first cycle busy_i is low after a read request
- busy_i  input  1  SRAM wrapper busy
- restart  input  1  one-cycle pulse; in DONE, starts a new scan
- wr_r_en  output  2  SRAM command: 2'd0 = read, 2'd3 = idle (this block never writes)
- addr  output  9  SRAM word address
- least1  output  9  index of the smallest count; 9'h1FF means invalid
- least2  output  9  index of the second-smallest count; 9'h1FF means invalid
- cnt1  output  32  count of least1
- cnt2  output  32  count of least2
- sum  output  32  cnt1+cnt2 modulo 2^32; equals cnt1 when least2 is invalid; 0 when neither is valid
- done  output  1  high while results are valid

Behaviour:
- All state, outputs and sequencing below apply only on cycles with en_state == EN_CODE; on all other cycles every register holds its value.

Reset values:
- FSM state IDLE, wr_r_en = 2'd3, addr = 0, index counter = 0.
- least1 = least2 = 9'h1FF, cnt1 = cnt2 = 32'hFFFFFFFF, sum = 0, done = 0.

State machine (IDLE, REQ, WAIT, CMP, DONE):
- IDLE: clears the index counter, least1/least2 to 9'h1FF, cnt1/cnt2 to FFFFFFFF and done to 0. It moves to REQ on the next enabled cycle.
- REQ: registered wr_r_en = 2'd0 and addr = BASE_ADDR+idx for exactly one cycle, then go to WAIT.
- WAIT: wr_r_en = 2'd3. On the first enabled cycle with busy_i = 0, latch sram_in into the data register and go to CMP.
- CMP: compare the latched data (rules below). If idx == NUM_ENTRIES-1, go to DONE; otherwise idx+1 and go to REQ.
- DONE: done = 1; sum is registered on entry; wr_r_en = 2'd3. The block stays in DONE until restart, which takes it to IDLE (done drops the next enabled cycle).
- Minimum latency is 3 cycles per entry. Total scan time is 3*NUM_ENTRIES+2 enabled cycles plus any busy stalls.

Comparison rules in CMP (d = latched data):
- d == 0 is skipped, so absent characters are never selected.
- If d < cnt1: least2/cnt2 take least1/cnt1, and least1/cnt1 take idx/d.
- Else if d < cnt2: least2/cnt2 take idx/d.
- All comparisons are strict and unsigned, so on a tie the lower index keeps priority. Equal counts in a file therefore give least1 = the lower index and least2 = the next index.
- A count of FFFFFFFF is never selected (it cannot occur in a valid file).

Boundary conditions:
- If fewer than two non-zero entries exist, least2 stays 9'h1FF. If no non-zero entries exist, both stay invalid and sum = 0.
- restart outside DONE is ignored.
- busy_i held high stalls WAIT indefinitely with wr_r_en = 2'd3 and addr unchanged.
- An en_state change in the middle of the scan freezes the block. The scan resumes exactly where it stopped, with no re-request, when en_state returns to EN_CODE.
- rst at any time forces reset values within the same cycle (asynchronous). A partial scan is discarded.

Test Plan:
- Histogram with counts 5 at index 'a' (0x61), 2 at 'b' (0x62), 9 at 'c' (0x63), all else 0 -> done = 1, least1 = 0x62, cnt1 = 2, least2 = 0x61, cnt2 = 5, sum = 7, after 3*256+2 cycles with busy_i = 0.
- Tie: counts of 3 at 0x10, 0x05 and 0x20 -> least1 = 0x05, least2 = 0x10, sum = 6.
- Single non-zero entry, count 4 at 0x1A -> least1 = 0x1A, least2 = 0x1FF, sum = 4. All-zero table -> both 0x1FF, sum = 0, done = 1.
- busy_i high for 10 cycles in WAIT on index 7 -> wr_r_en = 2'd3, addr = 7 held throughout; the result is identical to the no-stall run.
- en_state = 1 for 20 cycles mid-scan, then back to 2 -> addr and the index counter freeze and the scan completes with the correct result. restart pulsed mid-scan has no effect; restart pulsed in DONE -> done = 0 on the next cycle, then a new scan begins.
- rst asserted mid-scan -> outputs return to reset values immediately; after rst release, a full scan yields the correct result.
